sms_trigger_binary_bank: RTL
============================

// Module: sms_trigger_binary_bank
//
// PURPOSE
//   N-stage bank of SDTRL trigger binaries, clocked successor of the single-stage TAJ card.
//   Each stage has gated AC set-left/set-right/complement inputs and DC reset-left/right levels.
//   With CHAIN=1 the stages also form a binary counter advanced by count_in, with carry out.
//   Sits in the card library and feeds counter/register logic (e.g. digit and address counters).
//
// PARAMETERS
//   WIDTH      4        number of trigger stages (1..16)
//   CHAIN      1        1: count_in increments q as a binary counter; 0: count_in ignored
//   RESET_VAL  {WIDTH{1'b1}}  q value loaded by rst_n (matches TAJ power-on state 1)
//
// PORTS
//   clk         in   1      single system clock, all state changes on posedge
//   rst_n       in   1      synchronous, active-low reset
//   ac_set_l    in   WIDTH  AC set left: rising edge clears stage (1->0) when gated
//   gate_l      in   WIDTH  gate for ac_set_l, level sampled on the same clk edge
//   ac_set_r    in   WIDTH  AC set right: rising edge sets stage (0->1) when gated
//   gate_r      in   WIDTH  gate for ac_set_r
//   ac_comp     in   WIDTH  complement input: rising edge toggles stage when gated
//   gate_comp   in   WIDTH  gate for ac_comp
//   dc_reset_l  in   WIDTH  level: forces stage to 1 while high
//   dc_reset_r  in   WIDTH  level: forces stage to 0 while high
//   count_in    in   1      rising edge = one count (CHAIN=1 only)
//   q           out  WIDTH  stage state (TAJ pin B)
//   q_n         out  WIDTH  ~q (TAJ pin P), always exact complement
//   carry_out   out  1      one-cycle pulse on count wrap all-ones -> 0
//
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): q=RESET_VAL, q_n=~RESET_VAL, carry_out=0; all edge-history
//     regs loaded with 1 so inputs held high across reset release give no spurious edge.
//   - Edge detect: event on input X at posedge when X=1 and X_prev=0; X_prev<=X every cycle.
//     Result visible in q immediately after the posedge that first samples X high (0-cycle
//     latency beyond sampling). Input must be low >=1 cycle between events.
//   - Gated events, per stage i, evaluated on current q[i]:
//       clr_i  = edge(ac_set_l[i]) & gate_l[i] & q[i]
//       set_i  = edge(ac_set_r[i]) & gate_r[i] & ~q[i]
//       tog_i  = edge(ac_comp[i])  & gate_comp[i]
//     Ungated edges and edges on a stage already in target state: no change.
//   - Count (CHAIN=1): cnt = edge(count_in); base = cnt ? q+1 (mod 2^WIDTH) : q.
//     carry_out = cnt & (q == all-ones), registered, high exactly one cycle.
//     CHAIN=0: base = q, carry_out held 0.
//   - Per-stage next-state priority (highest first):
//       1 dc_reset_r[i] -> 0      2 dc_reset_l[i] -> 1
//       3 clr_i -> 0 / set_i -> 1 (mutually exclusive by q[i])
//       4 tog_i -> ~q[i]          5 base[i]
//     carry_out is computed from q before overrides; overrides do not suppress it.
//   - DC reset is level only; releasing it leaves the forced value (no release-edge action).
//   - rst_n low mid-operation: all state and edge history reload next posedge; pending
//     edges are discarded.
//
// STRUCTURE
//   - sms_defs.vh (shared): priority encoding constants, default WIDTH, RESET_VAL macro.
//   - Sub-module sms_trigger_stage: one bit = edge history x3, gating, priority mux;
//     takes base bit from the parent. Parent owns count edge detect, adder, carry_out,
//     generate loop over WIDTH stages.
//
// TESTING
//   1 Reset: rst_n=0 1 cycle, WIDTH=4 -> q=4'b1111, q_n=4'b0000, carry_out=0.
//   2 Gating: ac_set_l[0] pulse with gate_l[0]=0 -> q unchanged 1111; repeat with gate_l[0]=1
//     -> q=1110; pulse again -> stays 1110; ac_set_r[0]+gate_r[0] -> 1111.
//   3 Count wrap: q=1110, 2 count_in pulses -> 1111 then 0000 with carry_out=1 for exactly
//     1 cycle; CHAIN=0 build -> q stays 1110, carry_out never high.
//   4 Priority: same cycle dc_reset_r[2]=1, tog_2 event, count edge from 0011 -> q=0000 bit2=0
//     (q=4'b0000); dc_reset_l[1] and dc_reset_r[1] both high -> q[1]=0.
//   5 Edge rules: ac_comp[3] held high 5 cycles with gate -> single toggle; input high through
//     rst_n release -> no toggle until low then high.
//   6 Reset mid-operation: count edge and rst_n=0 same posedge -> q=RESET_VAL, carry_out=0.

Source files
------------

// File: rtl/sms_trigger_binary_bank_pkg.sv
// Shared definitions for the SDTRL trigger binary bank: default geometry and
// the per-stage next-state source priority.
package sms_trigger_binary_bank_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   // Next-state sources in descending priority order.
   typedef enum logic [2:0] {
      SRC_DC_R  = 3'd0,
      SRC_DC_L  = 3'd1,
      SRC_GATED = 3'd2,
      SRC_TOG   = 3'd3,
      SRC_BASE  = 3'd4
   } src_e;

   function automatic src_e stage_src(input logic dc_r, input logic dc_l,
                                      input logic gated, input logic tog);
      src_e src;
      if (dc_r)       src = SRC_DC_R;
      else if (dc_l)  src = SRC_DC_L;
      else if (gated) src = SRC_GATED;
      else if (tog)   src = SRC_TOG;
      else            src = SRC_BASE;
      return src;
   endfunction

endpackage

// File: rtl/sms_trigger_binary_bank_stage.sv
// One trigger binary: rising-edge detect on the three AC inputs, gating against
// the current state, and the DC-reset / AC / base-bit priority mux.
module sms_trigger_stage
   import sms_trigger_binary_bank_pkg::*;
#(
   parameter logic RESET_BIT = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ac_set_l,
   input  logic gate_l,
   input  logic ac_set_r,
   input  logic gate_r,
   input  logic ac_comp,
   input  logic gate_comp,
   input  logic dc_reset_l,
   input  logic dc_reset_r,
   input  logic base_bit,
   output logic q
);

   logic q_q, q_d;
   logic set_l_prev_q, set_r_prev_q, comp_prev_q;
   logic clr_ev, set_ev, tog_ev;

   assign clr_ev = ac_set_l & ~set_l_prev_q & gate_l & q_q;
   assign set_ev = ac_set_r & ~set_r_prev_q & gate_r & ~q_q;
   assign tog_ev = ac_comp  & ~comp_prev_q  & gate_comp;

   always_comb begin
      q_d = base_bit;
      // clr and set are mutually exclusive by q_q, so set_ev alone is the target.
      unique case (stage_src(dc_reset_r, dc_reset_l, clr_ev | set_ev, tog_ev))
         SRC_DC_R:  q_d = 1'b0;
         SRC_DC_L:  q_d = 1'b1;
         SRC_GATED: q_d = set_ev;
         SRC_TOG:   q_d = ~q_q;
         default:   q_d = base_bit;
      endcase
   end

   // History loads high on reset so inputs held high across release are not edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q          <= RESET_BIT;
         set_l_prev_q <= 1'b1;
         set_r_prev_q <= 1'b1;
         comp_prev_q  <= 1'b1;
      end else begin
         q_q          <= q_d;
         set_l_prev_q <= ac_set_l;
         set_r_prev_q <= ac_set_r;
         comp_prev_q  <= ac_comp;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/sms_trigger_binary_bank.sv
// N-stage bank of trigger binaries; optionally chained as a binary counter
// advanced by rising edges of count_in, with a one-cycle wrap carry.
module sms_trigger_binary_bank
   import sms_trigger_binary_bank_pkg::*;
#(
   parameter int unsigned          WIDTH     = DEF_WIDTH,
   parameter int unsigned          CHAIN     = 1,
   parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] ac_set_l,
   input  logic [WIDTH-1:0] gate_l,
   input  logic [WIDTH-1:0] ac_set_r,
   input  logic [WIDTH-1:0] gate_r,
   input  logic [WIDTH-1:0] ac_comp,
   input  logic [WIDTH-1:0] gate_comp,
   input  logic [WIDTH-1:0] dc_reset_l,
   input  logic [WIDTH-1:0] dc_reset_r,
   input  logic             count_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             carry_out
);

   logic             chain_en;
   logic             count_prev_q;
   logic             carry_q, carry_d;
   logic             cnt_ev;
   logic [WIDTH-1:0] base;

   assign chain_en = (CHAIN != 0);
   assign cnt_ev   = chain_en & count_in & ~count_prev_q;
   assign base     = cnt_ev ? q + WIDTH'(1) : q;
   // Carry is judged on the pre-override state, so DC/AC overrides never mask it.
   assign carry_d  = cnt_ev & (&q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_prev_q <= 1'b1;
         carry_q      <= 1'b0;
      end else begin
         count_prev_q <= count_in;
         carry_q      <= carry_d;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
         sms_trigger_stage #(
            .RESET_BIT (RESET_VAL[gi])
         ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .ac_set_l   (ac_set_l[gi]),
            .gate_l     (gate_l[gi]),
            .ac_set_r   (ac_set_r[gi]),
            .gate_r     (gate_r[gi]),
            .ac_comp    (ac_comp[gi]),
            .gate_comp  (gate_comp[gi]),
            .dc_reset_l (dc_reset_l[gi]),
            .dc_reset_r (dc_reset_r[gi]),
            .base_bit   (base[gi]),
            .q          (q[gi])
         );
      end
   endgenerate

   assign q_n       = ~q;
   assign carry_out = carry_q;

endmodule
